// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared constants, bit-order enum and fill-counter width helper
//            for the LZS input bit-stream extractor.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam int DEF_IN_W  = 64;
    localparam int DEF_MAX_W = 13;
    localparam int DEF_WID_W = 4;

    typedef enum logic {
        BO_LSB = 1'b0,
        BO_MSB = 1'b1
    } bit_order_e;

    // Fill counter must hold every value from 0 to a full two-word buffer.
    function automatic int calc_cnt_w(input int in_w);
        return $clog2(2 * in_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_bitalign.sv
`default_nettype none
// ============================================================================
// Module   : decode_bitalign
// Brief    : Combinational consume-shift and word-append for the bit buffer.
//            Removes w leading bits, then merges a popped word directly
//            behind the bits that remain.
// Revision : 1.0 - initial release
// ============================================================================
module decode_bitalign
    import decode_pkg::*;
#(
    parameter  int IN_W      = DEF_IN_W,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int BUF_W     = 2 * IN_W,
    localparam int CNT_W     = calc_cnt_w(IN_W)
) (
    input  logic [BUF_W-1:0] buf_cur,
    input  logic [CNT_W-1:0] cnt_cur,
    input  logic [CNT_W-1:0] w,
    input  logic [IN_W-1:0]  fi,
    input  logic             pop,
    output logic [BUF_W-1:0] buf_next,
    output logic [CNT_W-1:0] cnt_next
);

    localparam bit_order_e       ORDER  = MSB_FIRST ? BO_MSB : BO_LSB;
    localparam logic [CNT_W-1:0] C_IN_W = CNT_W'(IN_W);

    logic [CNT_W-1:0] rem;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;

    // Remaining bits after the consume (tail acks may over-consume) plus any new word.
    always_comb begin
        rem      = (cnt_cur > w) ? (cnt_cur - w) : '0;
        cnt_next = rem + (pop ? C_IN_W : '0);
    end

    generate
        if (ORDER == BO_MSB) begin : g_msb
            // Oldest bits live at the top; new word lands just below the remainder.
            always_comb begin
                shifted = buf_cur << w;
                placed  = {fi, {IN_W{1'b0}}} >> rem;
            end
        end else begin : g_lsb
            // Oldest bits live at the bottom; new word lands just above the remainder.
            always_comb begin
                shifted = buf_cur >> w;
                placed  = {{IN_W{1'b0}}, fi} << rem;
            end
        end
    endgenerate

    // Bits beyond the fill level are zero, so a plain OR merges the word.
    always_comb begin
        buf_next = shifted | (pop ? placed : '0);
    end

endmodule
`default_nettype wire

// File: rtl/decode_bitstream.sv
`default_nettype none
// ============================================================================
// Module   : decode_bitstream
// Brief    : LZS input bit-stream extractor. Pops words from a FWFT FIFO into
//            a two-word bit buffer, presents the next MAX_W bits and consumes
//            a variable-width field per acknowledge.
// Revision : 1.0 - initial release
// ============================================================================
module decode_bitstream
    import decode_pkg::*;
#(
    parameter  int IN_W      = DEF_IN_W,
    parameter  int MAX_W     = DEF_MAX_W,
    parameter  int WID_W     = DEF_WID_W,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int CNT_W     = calc_cnt_w(IN_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             fo_full,
    input  logic             src_empty,
    input  logic [IN_W-1:0]  fi,
    input  logic             m_last,
    output logic             m_src_getn,
    output logic [MAX_W-1:0] stream_data,
    output logic             stream_valid,
    input  logic [WID_W-1:0] stream_width,
    input  logic             stream_ack,
    output logic             stream_done,
    output logic [CNT_W-1:0] level_o,
    output logic             err_o
);

    localparam int               BUF_W       = 2 * IN_W;
    localparam logic [CNT_W-1:0] C_MAX_W_CNT = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0] C_IN_W_CNT  = CNT_W'(IN_W);
    localparam logic [WID_W-1:0] C_MAX_W_WID = WID_W'(MAX_W);

    logic [BUF_W-1:0] bit_buf;
    logic [BUF_W-1:0] buf_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] w;
    logic [WID_W-1:0] w_clamped;
    logic             last_seen;
    logic             done;
    logic             err;
    logic             run;
    logic             pop;
    logic             ack_any;
    logic             bad_width;
    logic             take;

    // Pop/consume decisions; pop never looks at stream_ack so it cannot loop back.
    always_comb begin
        run          = ce & ~fo_full & ~rst;
        stream_valid = (cnt >= C_MAX_W_CNT) | (last_seen & (cnt != '0) & ~done);
        pop          = run & ~src_empty & ~last_seen & (cnt <= C_IN_W_CNT);
        ack_any      = run & stream_ack & ~done;
        bad_width    = (stream_width == '0) | (stream_width > C_MAX_W_WID);
        take         = ack_any & stream_valid;
        w_clamped    = (stream_width > C_MAX_W_WID) ? C_MAX_W_WID : stream_width;
        w            = take ? CNT_W'(w_clamped) : '0;
        m_src_getn   = ~pop;
    end

    decode_bitalign #(
        .IN_W      (IN_W),
        .MSB_FIRST (MSB_FIRST)
    ) u_align (
        .buf_cur   (bit_buf),
        .cnt_cur   (cnt),
        .w         (w),
        .fi        (fi),
        .pop       (pop),
        .buf_next  (buf_nxt),
        .cnt_next  (cnt_nxt)
    );

    // Buffer, fill level, end-of-stream and sticky error registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_buf   <= '0;
            cnt       <= '0;
            last_seen <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (run) begin
            bit_buf <= buf_nxt;
            cnt     <= cnt_nxt;
            if (pop) begin
                last_seen <= m_last;
            end
            if (last_seen && (cnt_nxt == '0)) begin
                done <= 1'b1;
            end
            if (ack_any && (bad_width || !stream_valid)) begin
                err <= 1'b1;
            end
        end
    end

    generate
        if (MSB_FIRST) begin : g_out_msb
            assign stream_data = bit_buf[BUF_W-1 -: MAX_W];
        end else begin : g_out_lsb
            assign stream_data = bit_buf[MAX_W-1:0];
        end
    endgenerate

    assign stream_done = done;
    assign level_o     = cnt;
    assign err_o       = err;

endmodule
`default_nettype wire

// File: doc/decode_bitstream.md
Name: decode_bitstream

Overview:
- Parametrised successor to the LZS decoder's input bit-stream extractor.
- Pops IN_W-bit words from a first-word-fall-through source FIFO into a 2*IN_W-bit bit buffer.
- Presents the next MAX_W bits to the LZS control FSM; on acknowledge, consumes a variable number of bits.
- New over the previous generation: configurable word/field widths, MSB- or LSB-first bit order, zero-padded tail fields, fill-level output and a sticky protocol-error flag.

Parameters:
IN_W, 64, source word width in bits (multiple of 8, >= 2*MAX_W)
MAX_W, 13, maximum field width presented per cycle
WID_W, 4, width of stream_width (2**WID_W > MAX_W)
MSB_FIRST, 1, 1 = bits taken from word MSB downward; 0 = from LSB upward
CNT_W, $clog2(2*IN_W+1), derived fill-counter width (localparam)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
ce  in  1  clock enable; low freezes all state
fo_full  in  1  downstream output full; high freezes all state
src_empty  in  1  source FIFO empty
fi  in  IN_W  source FIFO head word (valid when !src_empty)
m_last  in  1  head word is the final word of the stream
m_src_getn  out  1  active-low FIFO pop strobe, combinational
stream_data  out  MAX_W  next MAX_W unconsumed bits, aligned per MSB_FIRST
stream_valid  out  1  stream_data holds usable bits
stream_width  in  WID_W  bits to consume on ack (1..MAX_W)
stream_ack  in  1  consume stream_width bits this cycle
stream_done  out  1  all bits of the final word consumed
level_o  out  CNT_W  buffered unconsumed bit count
err_o  out  1  sticky protocol error

Behaviour:
- State: buf[2*IN_W-1:0], cnt (0..2*IN_W), last_seen, done, err.
- Reset: buf=0, cnt=0, last_seen=0, done=0, err=0 → m_src_getn=1, stream_valid=0, stream_done=0, stream_data=0, level_o=0, err_o=0.
- run = ce & !fo_full & !rst. With run=0, no state changes, stream_ack is ignored, and m_src_getn=1.
- Pop: m_src_getn = !(run & !src_empty & !last_seen & cnt <= IN_W). Depends only on registers and inputs, never on stream_ack.
  - On pop: last_seen <= m_last.
  - The word is appended behind the remaining bits after this cycle's consume.
  - A popped word's bits are visible on stream_data the next cycle.
- Consume: w = stream_width when run & stream_ack & stream_valid, else 0.
  - MSB_FIRST=1: buf shifts left by w.
  - MSB_FIRST=0: buf shifts right by w.
  - cnt_next = sat0(cnt - w) + (pop ? IN_W : 0). cnt never exceeds 2*IN_W.
  - Bits above cnt in buffer order are always 0. Vacated bits fill with 0.
- Append position:
  - MSB_FIRST=1: word placed at buf[2*IN_W-1-c' -: IN_W], with fi bit IN_W-1 first.
  - MSB_FIRST=0: word placed at buf[c' +: IN_W], with fi bit 0 first.
  - c' = sat0(cnt - w).
- Output fields (registered state, combinational decode):
  - stream_data = buf[2*IN_W-1 -: MAX_W] (MSB_FIRST=1) or buf[MAX_W-1:0] (MSB_FIRST=0).
  - stream_valid = (cnt >= MAX_W) | (last_seen & cnt != 0 & !done). Tail fields are zero-padded.
- Tail:
  - Once last_seen, an ack with w > cnt is legal and saturates cnt to 0.
  - done <= 1 on the cycle cnt_next==0 while last_seen (or last_seen already set).
  - done holds until reset; stream_done = done.
  - After done, no further pops; acks are ignored.
- Errors (err sets, sticky until reset; the consume still applies with w clamped to MAX_W, else ignored):
  - ack with stream_width==0 or > MAX_W;
  - ack while !stream_valid.
- Simultaneous pop and ack in one cycle is the normal streaming case and must not bubble.
- With ack of MAX_W every cycle and a non-empty FIFO, stream_valid stays continuously high.
- Reset asserted mid-stream discards buffered bits and the last flag; the next stream starts clean on the cycle after rst falls.

Decomposition:
- Package decode_pkg holds:
  - default IN_W/MAX_W/WID_W constants;
  - a bit-order enum {BO_LSB=0, BO_MSB=1};
  - the function computing CNT_W.
- One sub-module, decode_bitalign: combinational shift-and-merge.
  - Inputs: buf, cnt, w, fi, pop.
  - Outputs: next buf, next cnt.
  - Parametrised by IN_W and MSB_FIRST.
- The top holds registers, pop logic, done/err and outputs.

Test Plan:
1. MSB_FIRST=1, single word fi=64'hF000_0000_0000_0001 with m_last=1 → getn low 1 cycle.
   - Next cycle: stream_data=13'h1E00, level_o=64.
   - Ack w=4 → stream_data=13'h0000, level_o=60.
   - Ack w=13 four times → level_o=8, stream_data=13'h0020 (valid via tail).
   - Ack w=13 → level_o=0, stream_done=1, no err.
2. MSB_FIRST=0, fi=64'h0000_0000_0000_0ABC, m_last=1 → stream_data=13'h0ABC; ack w=8 → stream_data=13'h000A.
3. Streaming: 3 words in FIFO, ack w=13 every cycle.
   - stream_valid never drops before the tail.
   - Pops occur exactly on cycles with level_o <= 64.
   - Concatenated fields match the reference bit stream.
4. Stall: fo_full=1 (then ce=0) for 5 cycles with ack=1 and FIFO non-empty → buf/level_o/getn unchanged, getn=1; resumes identically after release.
5. Errors: ack w=0, then ack w=14, then ack while stream_valid=0 → err_o=1 after the first and stays 1; rst clears it.
6. Reset mid-stream with level_o=70 and last_seen=0 → next cycle all outputs at reset values; a new 1-word stream decodes correctly.
